// File: rtl/remap_seq.sv
// remap_seq: sequenced, runtime-configurable piecewise-linear m1->m2 remap.
// Holds node/intercept tables loaded through a config port. On commit it
// verifies that the nodes are strictly increasing, then serves samples.
// Each sample gets a range check, a fixed-length binary search for its piece,
// and a segment shift/add step that produces the result.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   cfg_we/sel/addr/wdata/commit  table write / verify request
//   cfg_ready, cfg_err            config accepted, sticky config error
//   table_valid                   tables verified, sample path enabled
//   in_valid/in_ready/in_m1       upstream sample handshake
//   out_valid/out_ready           downstream result handshake
//   out_m2/out_oor/out_piece      result, out-of-range flag, piece index
module remap_seq #(
  parameter int unsigned M1_W         = 16,
  parameter int unsigned M2_W         = 15,
  parameter int unsigned NODE_NUM     = 42,
  parameter int unsigned PIECE_NUM    = 41,
  parameter int unsigned SEG1_NUM     = 10,
  parameter int unsigned SEG2_NUM     = 10,
  parameter int unsigned SEG3_NUM     = 10,
  parameter int unsigned SEARCH_ITERS = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cfg_we,
  input  logic            cfg_sel,
  input  logic [5:0]      cfg_addr,
  input  logic [M1_W-1:0] cfg_wdata,
  input  logic            cfg_commit,
  output logic            cfg_ready,
  output logic            cfg_err,
  output logic            table_valid,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [M1_W-1:0] in_m1,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [M2_W-1:0] out_m2,
  output logic            out_oor,
  output logic [5:0]      out_piece
);

  localparam int unsigned AW = 6;
  localparam int unsigned CW = $clog2(SEARCH_ITERS + 1);

  localparam logic [AW-1:0] LAST_NODE  = AW'(NODE_NUM - 1);
  localparam logic [AW-1:0] LAST_PIECE = AW'(PIECE_NUM - 1);
  localparam logic [AW-1:0] LAST_K     = AW'(NODE_NUM - 2);
  localparam logic [AW-1:0] SEG2_START = AW'(SEG1_NUM);
  localparam logic [AW-1:0] SEG3_START = AW'(SEG1_NUM + SEG2_NUM);
  localparam logic [AW-1:0] SEG4_START = AW'(SEG1_NUM + SEG2_NUM + SEG3_NUM);
  localparam logic [AW-1:0] NODE_LIM   = AW'(NODE_NUM);
  localparam logic [AW-1:0] PIECE_LIM  = AW'(PIECE_NUM);
  localparam logic [CW-1:0] LAST_ITER  = CW'(SEARCH_ITERS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_VERIFY, S_READY, S_CHECK, S_SEARCH, S_CALC, S_OUT
  } state_e;

  state_e              state_q, state_d;
  logic [M1_W-1:0]     node_q   [NODE_NUM];
  logic [M1_W-1:0]     intcpt_q [PIECE_NUM];
  logic [M1_W-1:0]     m1_q, m1_d;
  logic [AW-1:0]       lo_q, lo_d, hi_q, hi_d, vk_q, vk_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                oor_q, oor_d;
  logic                cfg_ready_q, cfg_ready_d;
  logic                cfg_err_q, cfg_err_d;
  logic                tv_q, tv_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic [M2_W-1:0]     out_m2_q, out_m2_d;
  logic                out_oor_q, out_oor_d;
  logic [AW-1:0]       out_piece_q, out_piece_d;
  logic                node_we, intcpt_we;

  logic                addr_ok, wr_req, wr_ok, hs;
  logic [AW-1:0]       mid, vk_next;
  logic [M1_W-1:0]     adder, sum;

  // Segment adder and result sum for the piece currently held in lo_q.
  always_comb begin
    adder = '0;
    if (lo_q < SEG2_START)      adder = m1_q << 2;
    else if (lo_q < SEG3_START) adder = '0;
    else if (lo_q < SEG4_START) adder = M1_W'(-(m1_q >> 3));
    else                        adder = M1_W'(-(m1_q >> 2));
    sum = m1_q + adder + intcpt_q[lo_q];
  end

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    m1_d        = m1_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    vk_d        = vk_q;
    cnt_d       = cnt_q;
    oor_d       = oor_q;
    cfg_err_d   = cfg_err_q;
    tv_d        = tv_q;
    out_m2_d    = out_m2_q;
    out_oor_d   = out_oor_q;
    out_piece_d = out_piece_q;
    node_we     = 1'b0;
    intcpt_we   = 1'b0;

    addr_ok = cfg_sel ? (cfg_addr < PIECE_LIM) : (cfg_addr < NODE_LIM);
    wr_req  = cfg_ready_q && cfg_we;
    wr_ok   = wr_req && addr_ok;
    hs      = in_valid && in_ready_q;
    mid     = AW'(({1'b0, lo_q} + {1'b0, hi_q}) >> 1);
    vk_next = vk_q + AW'(1);

    unique case (state_q)
      S_IDLE, S_READY: begin
        if (wr_req && !addr_ok) cfg_err_d = 1'b1;
        // A good write invalidates the tables; a sample offered in the same
        // cycle is consumed and dropped since the tables are now unverified.
        if (wr_ok) begin
          node_we   = !cfg_sel;
          intcpt_we = cfg_sel;
          tv_d      = 1'b0;
          state_d   = S_IDLE;
        end else if (cfg_ready_q && !cfg_we && cfg_commit && state_q == S_IDLE) begin
          cfg_err_d = 1'b0;
          vk_d      = '0;
          state_d   = S_VERIFY;
        end else if (state_q == S_READY && hs) begin
          m1_d    = in_m1;
          state_d = S_CHECK;
        end
      end
      S_VERIFY: begin
        if (node_q[vk_q] < node_q[vk_next]) begin
          if (vk_q == LAST_K) begin
            tv_d    = 1'b1;
            state_d = S_READY;
          end else begin
            vk_d = vk_next;
          end
        end else begin
          cfg_err_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_CHECK: begin
        // Out-of-range samples collapse the window to one piece so the
        // search holds, keeping latency identical for all samples.
        cnt_d   = '0;
        state_d = S_SEARCH;
        if (m1_q <= node_q[0]) begin
          lo_d = '0;          hi_d = AW'(1);    oor_d = 1'b1;
        end else if (m1_q > node_q[LAST_NODE]) begin
          lo_d = LAST_PIECE;  hi_d = LAST_NODE; oor_d = 1'b1;
        end else begin
          lo_d = '0;          hi_d = LAST_NODE; oor_d = 1'b0;
        end
      end
      S_SEARCH: begin
        // Invariant: node[lo] < m1 <= node[hi].
        if ((hi_q - lo_q) > AW'(1)) begin
          if (m1_q <= node_q[mid]) hi_d = mid;
          else                     lo_d = mid;
        end
        if (cnt_q == LAST_ITER) state_d = S_CALC;
        else                    cnt_d   = cnt_q + CW'(1);
      end
      S_CALC: begin
        out_m2_d    = M2_W'(sum >> 1);
        out_oor_d   = oor_q;
        out_piece_d = lo_q;
        state_d     = S_OUT;
      end
      S_OUT: begin
        if (out_ready) state_d = S_READY;
      end
      default: state_d = S_IDLE;
    endcase

    cfg_ready_d = (state_d == S_IDLE) || (state_d == S_READY);
    in_ready_d  = (state_d == S_READY) && tv_d;
    out_valid_d = (state_d == S_OUT);
  end

  // State, datapath and table registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      m1_q        <= '0;
      lo_q        <= '0;
      hi_q        <= '0;
      vk_q        <= '0;
      cnt_q       <= '0;
      oor_q       <= 1'b0;
      cfg_ready_q <= 1'b0;
      cfg_err_q   <= 1'b0;
      tv_q        <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_m2_q    <= '0;
      out_oor_q   <= 1'b0;
      out_piece_q <= '0;
      for (int unsigned i = 0; i < NODE_NUM; i++)  node_q[i]   <= '0;
      for (int unsigned i = 0; i < PIECE_NUM; i++) intcpt_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      m1_q        <= m1_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      vk_q        <= vk_d;
      cnt_q       <= cnt_d;
      oor_q       <= oor_d;
      cfg_ready_q <= cfg_ready_d;
      cfg_err_q   <= cfg_err_d;
      tv_q        <= tv_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_m2_q    <= out_m2_d;
      out_oor_q   <= out_oor_d;
      out_piece_q <= out_piece_d;
      if (node_we)   node_q[cfg_addr]   <= cfg_wdata;
      if (intcpt_we) intcpt_q[cfg_addr] <= cfg_wdata;
    end
  end

  assign cfg_ready   = cfg_ready_q;
  assign cfg_err     = cfg_err_q;
  assign table_valid = tv_q;
  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_m2      = out_m2_q;
  assign out_oor     = out_oor_q;
  assign out_piece   = out_piece_q;

endmodule

// File: tb/tb_remap_seq.sv
// Testbench for remap_seq: directed config/sample sequences checked against
// a behavioural table-lookup model, with literal pins on the model.
module tb_remap_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_we, cfg_sel, cfg_commit;
  logic [5:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic        cfg_ready, cfg_err, table_valid;
  logic        in_valid, in_ready;
  logic [15:0] in_m1;
  logic        out_valid, out_ready;
  logic [14:0] out_m2;
  logic        out_oor;
  logic [5:0]  out_piece;

  remap_seq dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_commit(cfg_commit),
    .cfg_ready(cfg_ready), .cfg_err(cfg_err), .table_valid(table_valid),
    .in_valid(in_valid), .in_ready(in_ready), .in_m1(in_m1),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_m2(out_m2), .out_oor(out_oor), .out_piece(out_piece)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Intended table contents and pending-result scoreboard.
  int tn [42];
  int ti [41];
  bit mon_en = 1'b0;
  bit pend   = 1'b0;
  int hs_cyc = 0;
  int e_m2, e_oor, e_piece;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out (t=%0t)", nm, $time);
  endtask

  // Reference: linear scan for the piece, then segment rule in plain ints.
  function automatic void model(input int m1, output int p, output int o, output int m2);
    int adder, sum, seg;
    p = 0;
    if (m1 <= tn[0]) begin
      o = 1;
    end else if (m1 > tn[41]) begin
      p = 40; o = 1;
    end else begin
      o = 0;
      for (int k = 0; k < 41; k++)
        if (tn[k] < m1 && m1 <= tn[k+1]) p = k;
    end
    seg = p / 10;
    if (seg > 3) seg = 3;
    case (seg)
      0:       adder = 4 * m1;
      1:       adder = 0;
      2:       adder = -(m1 / 8);
      default: adder = -(m1 / 4);
    endcase
    sum = (m1 + adder + ti[p]) & 32'h0000FFFF;
    m2  = sum / 2;
  endfunction

  // Per-cycle output check against the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      if (pend) begin
        chk("in_ready_busy", in_ready, 0);
        if (cyc - hs_cyc < 8) begin
          chk("out_valid_early", out_valid, 0);
        end else begin
          chk("out_valid", out_valid, 1);
          chk("out_m2", out_m2, e_m2);
          chk("out_oor", out_oor, e_oor);
          chk("out_piece", out_piece, e_piece);
          if (out_ready) pend = 1'b0;
        end
      end else begin
        chk("out_valid_idle", out_valid, 0);
      end
    end
  end

  task automatic cfg_wr(input logic sel, input int addr, input int data, input logic commit);
    int n = 0;
    @(negedge clk);
    while (cfg_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) fail_now("cfg_ready_wait");
    cfg_we = 1'b1; cfg_sel = sel; cfg_addr = 6'(addr);
    cfg_wdata = 16'(data); cfg_commit = commit;
    @(posedge clk); #1;
    cfg_we = 1'b0; cfg_commit = 1'b0;
    if (!sel && addr < 42) tn[addr] = data;
    if (sel && addr < 41)  ti[addr] = data;
  endtask

  task automatic do_commit(output int n);
    @(negedge clk);
    cfg_commit = 1'b1;
    @(posedge clk); #1;
    cfg_commit = 1'b0;
    n = 0;
    while (table_valid !== 1'b1 && cfg_err !== 1'b1 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) fail_now("commit_wait");
  endtask

  task automatic send_start(input int m1);
    int n = 0;
    model(m1, e_piece, e_oor, e_m2);
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) fail_now("in_ready_wait");
    in_valid = 1'b1; in_m1 = 16'(m1);
    @(posedge clk); #1;
    hs_cyc = cyc; pend = 1'b1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (pend && n < 40) begin @(posedge clk); n++; end
    if (pend) begin fail_now("result_wait"); pend = 1'b0; end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cfg_ready"}, cfg_ready, 0);
    chk({tag, "_cfg_err"}, cfg_err, 0);
    chk({tag, "_table_valid"}, table_valid, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_m2"}, out_m2, 0);
    chk({tag, "_out_oor"}, out_oor, 0);
    chk({tag, "_out_piece"}, out_piece, 0);
  endtask

  int lit_m1 [7] = '{250, 300, 1550, 2550, 3650, 0, 5000};
  int lit_p  [7] = '{2, 2, 15, 25, 36, 0, 40};
  int lit_o  [7] = '{0, 0, 0, 0, 0, 1, 1};
  int lit_m2 [7] = '{626, 751, 782, 1128, 1387, 0, 1895};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, p, o, m2;
    rst_n = 1'b0; cfg_we = 1'b0; cfg_sel = 1'b0; cfg_commit = 1'b0;
    cfg_addr = '0; cfg_wdata = '0; in_valid = 1'b0; in_m1 = '0; out_ready = 1'b1;
    for (int i = 0; i < 42; i++) tn[i] = 0;
    for (int i = 0; i < 41; i++) ti[i] = 0;
    #12;
    chk_all_zero("reset");
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Load linear tables and verify.
    for (int i = 0; i < 42; i++) cfg_wr(1'b0, i, 100 * i, 1'b0);
    for (int i = 0; i < 41; i++) cfg_wr(1'b1, i, i, 1'b0);
    do_commit(n);
    chk("verify_cycles", n, 41);
    chk("verify_err", cfg_err, 0);
    chk("verify_tv", table_valid, 1);
    chk("verify_in_ready", in_ready, 1);

    // Pin the model, then run the same samples through the DUT.
    mon_en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      model(lit_m1[i], p, o, m2);
      chk("pin_piece", p, lit_p[i]);
      chk("pin_oor", o, lit_o[i]);
      chk("pin_m2", m2, lit_m2[i]);
      send_start(lit_m1[i]);
      wait_done();
    end
    send_start(1);     wait_done();
    send_start(65535); wait_done();
    send_start(4100);  wait_done();

    // Backpressure: result held for 5 extra cycles, then one transfer.
    @(posedge clk); #1 out_ready = 1'b0;
    send_start(1550);
    repeat (8) @(posedge clk);
    repeat (5) @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_in_ready_after", in_ready, 1);
    chk("bp_out_valid_after", out_valid, 0);

    // Same-cycle write and commit: write only, no verify.
    cfg_wr(1'b0, 5, 400, 1'b1);
    repeat (50) @(posedge clk);
    #1;
    chk("wc_err", cfg_err, 0);
    chk("wc_tv", table_valid, 0);
    chk("wc_cfg_ready", cfg_ready, 1);

    // Non-monotonic nodes (node[4]=node[5]=400).
    do_commit(n);
    chk("mono_err", cfg_err, 1);
    chk("mono_tv", table_valid, 0);
    chk("mono_in_ready", in_ready, 0);
    chk("mono_cfg_ready", cfg_ready, 1);

    cfg_wr(1'b0, 5, 500, 1'b0);
    do_commit(n);
    chk("fix_cycles", n, 41);
    chk("fix_err", cfg_err, 0);

    // Bad address write in IDLE: error set, tables unchanged.
    cfg_wr(1'b0, 3, 300, 1'b0);
    cfg_wr(1'b0, 50, 0, 1'b0);
    #1;
    chk("badaddr_err", cfg_err, 1);
    do_commit(n);
    chk("badaddr_recommit_err", cfg_err, 0);
    chk("badaddr_recommit_tv", table_valid, 1);
    send_start(3650); wait_done();

    // Reset during SEARCH.
    send_start(2550);
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b0; pend = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    for (int i = 0; i < 42; i++) tn[i] = 0;
    for (int i = 0; i < 41; i++) ti[i] = 0;
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);
    do_commit(n);
    chk("cleared_tables_err", cfg_err, 1);
    chk("cleared_tables_tv", table_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
